// File: rtl/watch_pkg.sv
// Shared watch display definitions: segment patterns, digit order, slot index type.
package watch_pkg;

   localparam int unsigned NUM_DIGITS = 6;
   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned SEG_W      = 7;
   localparam int unsigned VEC_W      = NUM_DIGITS * DIGIT_W;
   localparam int unsigned SLOT_W     = 3;
   localparam int unsigned CNT_W      = 16;

   typedef logic [SLOT_W-1:0] slot_idx_t;

   // Six BCD digits as they arrive from the counters, most significant first.
   typedef struct packed {
      logic [DIGIT_W-1:0] hour_10;
      logic [DIGIT_W-1:0] hour1;
      logic [DIGIT_W-1:0] min_10;
      logic [DIGIT_W-1:0] min1;
      logic [DIGIT_W-1:0] sec_10;
      logic [DIGIT_W-1:0] sec1;
   } digits_t;

   // Scan slot assigned to each digit; slot number equals dig_en bit.
   localparam slot_idx_t DIG_SEC1   = 3'd0;
   localparam slot_idx_t DIG_SEC10  = 3'd1;
   localparam slot_idx_t DIG_MIN1   = 3'd2;
   localparam slot_idx_t DIG_MIN10  = 3'd3;
   localparam slot_idx_t DIG_HOUR1  = 3'd4;
   localparam slot_idx_t DIG_HOUR10 = 3'd5;

   // Segment patterns {g,f,e,d,c,b,a}, active-high.
   localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/watch_display_scan_bcd_to_seg.sv
// Combinational BCD to seven-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
   import watch_pkg::*;
(
   input  logic [DIGIT_W-1:0] bcd,
   output logic [SEG_W-1:0]   seg_c
);

   // Pattern lookup with dash for codes 10..15.
   always_comb begin
      seg_c = SEG_DASH;
      case (bcd)
         4'd0:    seg_c = SEG_0;
         4'd1:    seg_c = SEG_1;
         4'd2:    seg_c = SEG_2;
         4'd3:    seg_c = SEG_3;
         4'd4:    seg_c = SEG_4;
         4'd5:    seg_c = SEG_5;
         4'd6:    seg_c = SEG_6;
         4'd7:    seg_c = SEG_7;
         4'd8:    seg_c = SEG_8;
         4'd9:    seg_c = SEG_9;
         default: seg_c = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/watch_display_scan.sv
// Six-digit multiplexed seven-segment scan driver with per-frame coherent snapshot.
module watch_display_scan
   import watch_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DIGIT_W-1:0]    hour_10,
   input  logic [DIGIT_W-1:0]    hour1,
   input  logic [DIGIT_W-1:0]    min_10,
   input  logic [DIGIT_W-1:0]    min1,
   input  logic [DIGIT_W-1:0]    sec_10,
   input  logic [DIGIT_W-1:0]    sec1,
   input  logic                  colon_on,
   input  logic                  blank_lz,
   output logic [SEG_W-1:0]      seg,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] dig_en
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   digits_t             din_c;
   digits_t             sync1, sync2, sync3, snap;
   logic                col_s1, col_s2;
   logic                snap_blz;
   logic [CNT_W-1:0]    cnt, cnt_nxt_c;
   slot_idx_t           idx, idx_nxt_c;
   logic                tc_c, frame_start_c, stable_c;
   logic [DIGIT_W-1:0]  cur_digit_c;
   logic [SEG_W-1:0]    dec_seg_c;
   logic [SEG_W-1:0]    seg_nxt_c;
   logic                dp_nxt_c;
   logic [NUM_DIGITS-1:0] en_nxt_c;

   assign din_c = '{hour_10: hour_10, hour1: hour1, min_10: min_10,
                    min1: min1, sec_10: sec_10, sec1: sec1};

   // Two-flop synchroniser plus compare stage for the asynchronous digits and colon.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1  <= '0;
         sync2  <= '0;
         sync3  <= '0;
         col_s1 <= 1'b0;
         col_s2 <= 1'b0;
      end else begin
         sync1  <= din_c;
         sync2  <= sync1;
         sync3  <= sync2;
         col_s1 <= colon_on;
         col_s2 <= col_s1;
      end
   end

   assign stable_c = (sync2 == sync3);

   // Prescaler and slot index next-state.
   always_comb begin
      cnt_nxt_c     = cnt + CNT_W'(1);
      idx_nxt_c     = idx;
      tc_c          = (cnt == CNT_LAST);
      frame_start_c = 1'b0;
      if (tc_c) begin
         cnt_nxt_c = '0;
         if (idx == DIG_HOUR10) begin
            idx_nxt_c     = DIG_SEC1;
            frame_start_c = 1'b1;
         end else begin
            idx_nxt_c = idx + slot_idx_t'(1);
         end
      end
   end

   // Scan counters and frame-start snapshot; an unstable vector keeps the old frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         idx      <= DIG_SEC1;
         snap     <= '0;
         snap_blz <= 1'b0;
      end else begin
         cnt <= cnt_nxt_c;
         idx <= idx_nxt_c;
         if (frame_start_c) begin
            snap_blz <= blank_lz;
            if (stable_c) snap <= sync2;
         end
      end
   end

   // Select the snapshot digit for the current slot.
   always_comb begin
      cur_digit_c = snap.sec1;
      case (idx)
         DIG_SEC10:  cur_digit_c = snap.sec_10;
         DIG_MIN1:   cur_digit_c = snap.min1;
         DIG_MIN10:  cur_digit_c = snap.min_10;
         DIG_HOUR1:  cur_digit_c = snap.hour1;
         DIG_HOUR10: cur_digit_c = snap.hour_10;
         default:    cur_digit_c = snap.sec1;
      endcase
   end

   bcd_to_seg u_dec (
      .bcd   (cur_digit_c),
      .seg_c (dec_seg_c)
   );

   // Output next values: blank at count 0, else enable, pattern, blanking and colon.
   always_comb begin
      seg_nxt_c = SEG_BLANK;
      dp_nxt_c  = 1'b0;
      en_nxt_c  = '0;
      if (cnt != '0) begin
         en_nxt_c  = NUM_DIGITS'(1) << idx;
         seg_nxt_c = dec_seg_c;
         if ((idx == DIG_HOUR10) && snap_blz && (cur_digit_c == '0))
            seg_nxt_c = SEG_BLANK;
         if (((idx == DIG_MIN1) || (idx == DIG_HOUR1)) && col_s2)
            dp_nxt_c = 1'b1;
      end
   end

   // Registered display outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg    <= '0;
         dp     <= 1'b0;
         dig_en <= '0;
      end else begin
         seg    <= seg_nxt_c;
         dp     <= dp_nxt_c;
         dig_en <= en_nxt_c;
      end
   end

endmodule

// File: tb/tb_watch_display_scan.sv
// Directed self-checking bench for watch_display_scan with SCAN_DIV=4.
module tb_watch_display_scan;

   logic       clk;
   logic       rst;
   logic [3:0] hour_10, hour1, min_10, min1, sec_10, sec1;
   logic       colon_on;
   logic       blank_lz;
   logic [6:0] seg;
   logic       dp;
   logic [5:0] dig_en;

   int checks = 0;
   int errors = 0;

   watch_display_scan #(.SCAN_DIV(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .hour_10  (hour_10),
      .hour1    (hour1),
      .min_10   (min_10),
      .min1     (min1),
      .sec_10   (sec_10),
      .sec1     (sec1),
      .colon_on (colon_on),
      .blank_lz (blank_lz),
      .seg      (seg),
      .dp       (dp),
      .dig_en   (dig_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [5:0] e_en,
                      input logic [6:0] e_seg, input logic e_dp);
      checks++;
      assert (dig_en === e_en && seg === e_seg && dp === e_dp)
      else begin
         errors++;
         $error("FAIL %s: got dig_en=%b seg=%h dp=%b, want dig_en=%b seg=%h dp=%b",
                tag, dig_en, seg, dp, e_en, e_seg, e_dp);
      end
   endtask

   // Called at the blank cycle of slot 0; returns at the blank cycle of the next frame.
   task automatic frame_check(input string tag, input logic [5:0][6:0] es,
                              input logic [5:0] dpm);
      for (int s = 0; s < 6; s++) begin
         chk($sformatf("%s s%0d blank", tag, s), 6'b0, 7'h00, 1'b0);
         for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("%s s%0d c%0d", tag, s, c), 6'b1 << s, es[s], dpm[s]);
         end
         @(negedge clk);
      end
   endtask

   task automatic set_time(input logic [3:0] h10, input logic [3:0] h1,
                           input logic [3:0] m10, input logic [3:0] m1,
                           input logic [3:0] s10, input logic [3:0] s1);
      hour_10 = h10; hour1 = h1; min_10 = m10; min1 = m1; sec_10 = s10; sec1 = s1;
   endtask

   initial begin
      rst      = 1'b0;
      colon_on = 1'b0;
      blank_lz = 1'b0;
      set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
      repeat (3) @(negedge clk);
      chk("in_reset", 6'b0, 7'h00, 1'b0);
      rst = 1'b1;
      @(negedge clk);

      // Reset snapshot shows zeros, then 12:34:56 appears from the next frame.
      frame_check("f1_zero", {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 6'b000000);
      frame_check("f2_123456", {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D}, 6'b000000);

      // Colon on; 09:05:00 with leading-zero blanking queued for the following frame.
      colon_on = 1'b1;
      blank_lz = 1'b1;
      set_time(4'd0, 4'd9, 4'd0, 4'd5, 4'd0, 4'd0);
      frame_check("f3_colon", {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D}, 6'b010100);

      // Blanking off and invalid min1 queued; current frame shows blanked hour_10.
      blank_lz = 1'b0;
      min1     = 4'hC;
      frame_check("f4_lz_blank", {7'h00, 7'h6F, 7'h3F, 7'h6D, 7'h3F, 7'h3F}, 6'b010100);

      colon_on = 1'b0;
      frame_check("f5_dash_nolz", {7'h3F, 7'h6F, 7'h3F, 7'h40, 7'h3F, 7'h3F}, 6'b000000);

      // sec1 toggles every clk across the next frame start: snapshot must hold.
      fork
         begin
            frame_check("f6_pre_toggle", {7'h3F, 7'h6F, 7'h3F, 7'h40, 7'h3F, 7'h3F}, 6'b000000);
            frame_check("f7_hold", {7'h3F, 7'h6F, 7'h3F, 7'h40, 7'h3F, 7'h3F}, 6'b000000);
         end
         begin
            repeat (20) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               sec1 = (i % 2 == 1) ? 4'd7 : 4'd3;
               @(negedge clk);
            end
         end
      join
      frame_check("f8_settled", {7'h3F, 7'h6F, 7'h3F, 7'h40, 7'h3F, 7'h07}, 6'b000000);

      // Reset in slot 3: outputs clear at once, scan restarts from a zero snapshot.
      repeat (13) @(negedge clk);
      chk("pre_reset_slot3", 6'b001000, 7'h3F, 1'b0);
      #2 rst = 1'b0;
      #1 chk("mid_reset_async", 6'b0, 7'h00, 1'b0);
      @(negedge clk);
      chk("mid_reset_held", 6'b0, 7'h00, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      frame_check("r1_zero", {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 6'b000000);
      frame_check("r2_reload", {7'h3F, 7'h6F, 7'h3F, 7'h40, 7'h3F, 7'h07}, 6'b000000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
